// File: rtl/mac_feed_pkg.sv
// Shared types and constants for the MAC operand feeder.
package mac_feed_pkg;

    localparam int unsigned OP_W    = 8;
    localparam int unsigned STALL_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } feed_state_t;

    typedef struct packed {
        logic            last;
        logic [OP_W-1:0] b;
        logic [OP_W-1:0] a;
    } feed_entry_t;

endpackage

// File: rtl/mac_operand_feeder_if.sv
// Upstream pair stream plus MAC issue/completion signals for the operand feeder.
interface mac_operand_feeder_if
    import mac_feed_pkg::*;
#(
    parameter int unsigned CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_a;
    logic [OP_W-1:0]  in_b;
    logic             in_last;
    logic             mac_finish;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic             mac_start;
    logic             busy;
    logic             vec_done;
    logic [CNT_W-1:0] pair_count;

    // Environment side: upstream producer and MAC controller.
    modport master (
        output in_valid, in_a, in_b, in_last, mac_finish,
        input  in_ready, op_a, op_b, mac_start, busy, vec_done, pair_count
    );

    // Feeder side.
    modport slave (
        input  in_valid, in_a, in_b, in_last, mac_finish,
        output in_ready, op_a, op_b, mac_start, busy, vec_done, pair_count
    );

endinterface

// File: rtl/feeder_fifo.sv
// Pair FIFO for the operand feeder: DEPTH entries, pointers carry an extra wrap bit.
module feeder_fifo
    import mac_feed_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  feed_entry_t wdata,
    output feed_entry_t rdata,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    feed_entry_t mem_q [DEPTH];
    feed_entry_t mem_d [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
            wptr_d                = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/mac_operand_feeder.sv
// Buffers operand pairs and issues them one at a time to the MAC, tracking vector ends.
// Optional sticky protocol error output enabled by defining MAC_FEED_ERR_EN.
module mac_operand_feeder
    import mac_feed_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mac_operand_feeder_if.slave  bus
`ifdef MAC_FEED_ERR_EN
    ,
    output logic                 err
`endif
);

    feed_state_t      state_q, state_d;
    logic [OP_W-1:0]  op_a_q, op_a_d;
    logic [OP_W-1:0]  op_b_q, op_b_d;
    logic             last_q, last_d;
    logic             mac_start_q, mac_start_d;
    logic             busy_q, busy_d;
    logic             vec_done_q, vec_done_d;
    logic [CNT_W-1:0] pair_count_q, pair_count_d;

    feed_entry_t      wr_entry;
    feed_entry_t      head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;

    assign wr_entry  = '{last: bus.in_last, b: bus.in_b, a: bus.in_a};
    assign fifo_push = bus.in_valid && !fifo_full;
    assign fifo_pop  = (state_q == ISSUE);

    feeder_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Operands are captured from the head on the edge entering ISSUE; the pop
    // itself retires the entry on the edge leaving ISSUE.
    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        last_d       = last_q;
        mac_start_d  = 1'b0;
        vec_done_d   = 1'b0;
        pair_count_d = pair_count_q;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d     = ISSUE;
                    op_a_d      = head.a;
                    op_b_d      = head.b;
                    last_d      = head.last;
                    mac_start_d = 1'b1;
                    if (pair_count_q != {CNT_W{1'b1}}) begin
                        pair_count_d = pair_count_q + 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.mac_finish) begin
                    state_d    = last_q ? DONE : IDLE;
                    vec_done_d = last_q;
                end
            end
            DONE: begin
                state_d      = IDLE;
                pair_count_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ISSUE) || (state_d == WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            last_q       <= 1'b0;
            mac_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            vec_done_q   <= 1'b0;
            pair_count_q <= '0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            last_q       <= last_d;
            mac_start_q  <= mac_start_d;
            busy_q       <= busy_d;
            vec_done_q   <= vec_done_d;
            pair_count_q <= pair_count_d;
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.op_a       = op_a_q;
    assign bus.op_b       = op_b_q;
    assign bus.mac_start  = mac_start_q;
    assign bus.busy       = busy_q;
    assign bus.vec_done   = vec_done_q;
    assign bus.pair_count = pair_count_q;

`ifdef MAC_FEED_ERR_EN
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               err_q, err_d;
    logic               stall;

    assign stall = bus.in_valid && fifo_full;

    // Error fires on the 256th consecutive stalled cycle.
    always_comb begin
        stall_cnt_d = '0;
        if (stall) begin
            stall_cnt_d = (stall_cnt_q == {STALL_W{1'b1}}) ? stall_cnt_q : stall_cnt_q + 1'b1;
        end
        err_d = err_q
              || (bus.mac_finish && (state_q != WAIT))
              || (stall && (stall_cnt_q == {STALL_W{1'b1}}));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed self-checking bench for mac_operand_feeder (DEPTH=4, CNT_W=4).
module tb_mac_operand_feeder;
    import mac_feed_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;

    logic clk;
    logic rst_n;
`ifdef MAC_FEED_ERR_EN
    logic err;
`endif

    mac_operand_feeder_if #(.CNT_W(CNT_W)) bus ();

    mac_operand_feeder #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef MAC_FEED_ERR_EN
        ,
        .err   (err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    int vd_cnt    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mac_start === 1'b1) start_cnt++;
        if (bus.vec_done === 1'b1) vd_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] a, input logic [7:0] b, input logic last);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        for (int i = 0; i < 64; i++) begin
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("push_accept", {31'd0, ok}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_start();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (bus.mac_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("start_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic finish_pulse();
        bus.mac_finish = 1'b1;
        tick();
        bus.mac_finish = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({tag, "_op_a"}, {24'd0, bus.op_a}, 32'd0);
        check({tag, "_op_b"}, {24'd0, bus.op_b}, 32'd0);
        check({tag, "_mac_start"}, {31'd0, bus.mac_start}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_vec_done"}, {31'd0, bus.vec_done}, 32'd0);
        check({tag, "_pair_count"}, {28'd0, bus.pair_count}, 32'd0);
    endtask

    logic [7:0] exp_a [3];
    logic [7:0] exp_b [3];
    int s0;
    int v0;
    int accepted;

    initial begin
        exp_a = '{8'd1, 8'd3, 8'd5};
        exp_b = '{8'd2, 8'd4, 8'd6};
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.in_last    = 1'b0;
        bus.mac_finish = 1'b0;
        rst_n          = 1'b0;

        // Reset values
        tick();
        tick();
        check_reset_outputs("rst");
`ifdef MAC_FEED_ERR_EN
        check("rst_err", {31'd0, err}, 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Single last pair: start two cycles after push, vec_done one after finish
        push_one(8'd3, 8'd5, 1'b1);
        check("t1_no_start_yet", {31'd0, bus.mac_start}, 32'd0);
        tick();
        check("t1_mac_start", {31'd0, bus.mac_start}, 32'd1);
        check("t1_op_a", {24'd0, bus.op_a}, 32'd3);
        check("t1_op_b", {24'd0, bus.op_b}, 32'd5);
        check("t1_busy", {31'd0, bus.busy}, 32'd1);
        check("t1_count", {28'd0, bus.pair_count}, 32'd1);
        tick();
        check("t1_start_one_cycle", {31'd0, bus.mac_start}, 32'd0);
        tick();
        tick();
        finish_pulse();
        check("t1_vec_done", {31'd0, bus.vec_done}, 32'd1);
        check("t1_idle_busy", {31'd0, bus.busy}, 32'd0);
        check("t1_op_a_held", {24'd0, bus.op_a}, 32'd3);
        tick();
        check("t1_vec_done_pulse", {31'd0, bus.vec_done}, 32'd0);
        check("t1_count_clear", {28'd0, bus.pair_count}, 32'd0);

        // Three pairs back-to-back, one vec_done after the third finish
        s0 = start_cnt;
        v0 = vd_cnt;
        push_one(8'd1, 8'd2, 1'b0);
        push_one(8'd3, 8'd4, 1'b0);
        push_one(8'd5, 8'd6, 1'b1);
        check("t2_first_start", start_cnt, s0 + 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t2_op_a_held", {24'd0, bus.op_a}, {24'd0, exp_a[k]});
            check("t2_op_b_held", {24'd0, bus.op_b}, {24'd0, exp_b[k]});
            finish_pulse();
            check("t2_vec_done", {31'd0, bus.vec_done}, (k == 2) ? 32'd1 : 32'd0);
            if (k < 2) begin
                wait_start();
                check("t2_op_a_issue", {24'd0, bus.op_a}, {24'd0, exp_a[k+1]});
                check("t2_count", {28'd0, bus.pair_count}, k + 2);
            end
        end
        tick();
        check("t2_starts", start_cnt, s0 + 3);
        check("t2_vec_dones", vd_cnt, v0 + 1);
        check("t2_count_clear", {28'd0, bus.pair_count}, 32'd0);

        // Fill: 5 accepted (one popped into WAIT, four queued), then stall
        s0 = start_cnt;
        accepted = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_a = 8'(16 + accepted);
            bus.in_b = 8'(32 + accepted);
            if (bus.in_ready === 1'b1) accepted++;
            tick();
        end
        bus.in_valid = 1'b0;
        check("t3_accepted", accepted, 32'd5);
        check("t3_full_ready", {31'd0, bus.in_ready}, 32'd0);
        check("t3_one_start", start_cnt, s0 + 1);
        check("t3_op_a", {24'd0, bus.op_a}, 32'd16);
        finish_pulse();
        wait_start();
        check("t3_op_a_next", {24'd0, bus.op_a}, 32'd17);
        check("t3_op_b_next", {24'd0, bus.op_b}, 32'd33);
        check("t3_ready_before_pop", {31'd0, bus.in_ready}, 32'd0);
        tick();
        check("t3_ready_after_pop", {31'd0, bus.in_ready}, 32'd1);

        // Reset in WAIT with queued pairs: immediate reset values, no issue after
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t4");
        tick();
        rst_n = 1'b1;
        s0 = start_cnt;
        repeat (6) tick();
        check("t4_no_start", start_cnt, s0);
        check("t4_idle", {31'd0, bus.busy}, 32'd0);

        // Spurious finish in IDLE is ignored
        s0 = start_cnt;
        v0 = vd_cnt;
        finish_pulse();
        tick();
        check("t5_busy", {31'd0, bus.busy}, 32'd0);
        check("t5_no_start", start_cnt, s0);
        check("t5_no_vec_done", vd_cnt, v0);
        check("t5_count", {28'd0, bus.pair_count}, 32'd0);
`ifdef MAC_FEED_ERR_EN
        check("t5_err_set", {31'd0, err}, 32'd1);
        repeat (3) tick();
        check("t5_err_sticky", {31'd0, err}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_err_clear", {31'd0, err}, 32'd0);
`endif

        // 17 pairs without last: count saturates at 15, then a last pair clears it
        for (int i = 0; i < 17; i++) begin
            push_one(8'(i), 8'(i + 1), 1'b0);
            wait_start();
            tick();
            finish_pulse();
            if (i == 0) check("t6_count_first", {28'd0, bus.pair_count}, 32'd1);
        end
        check("t6_count_sat", {28'd0, bus.pair_count}, 32'd15);
        v0 = vd_cnt;
        check("t6_no_vec_done", {31'd0, bus.vec_done}, 32'd0);
        push_one(8'd99, 8'd98, 1'b1);
        wait_start();
        check("t6_count_hold", {28'd0, bus.pair_count}, 32'd15);
        check("t6_op_a", {24'd0, bus.op_a}, 32'd99);
        tick();
        finish_pulse();
        check("t6_vec_done", {31'd0, bus.vec_done}, 32'd1);
        tick();
        check("t6_count_clear", {28'd0, bus.pair_count}, 32'd0);
        check("t6_vec_done_cnt", vd_cnt, v0 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
